// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with Hi/Lo result registers, one result bit per cycle.
// Latency: o_Done pulses WORD_LEN+1 cycles after the cycle i_Start is sampled; back-to-back every WORD_LEN+2 cycles.
// Backpressure: o_Busy high outside IDLE; i_Start/i_MTHI/i_MTLO are ignored while busy (no queueing).
//
// Ports:
//   i_CLK, i_RST                 clock, asynchronous active-high reset
//   i_Start, i_Op                start request and opcode (00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   i_Operand_A, i_Operand_B     rs / rt operands, latched when the request is accepted
//   i_MTHI, i_MTLO               direct writes of i_Operand_A into Hi / Lo while idle
//   o_Busy, o_Done               not-idle flag, one-cycle result-valid pulse
//   o_Div_By_Zero                last divide had a zero divisor (cleared on next accepted start)
//   o_Hi, o_Lo                   architectural Hi / Lo registers

module mult_div_unit #(
    parameter int WORD_LEN = 32
) (
    input  logic                i_CLK,
    input  logic                i_RST,
    input  logic                i_Start,
    input  logic [1:0]          i_Op,
    input  logic [WORD_LEN-1:0] i_Operand_A,
    input  logic [WORD_LEN-1:0] i_Operand_B,
    input  logic                i_MTHI,
    input  logic                i_MTLO,
    output logic                o_Busy,
    output logic                o_Done,
    output logic                o_Div_By_Zero,
    output logic [WORD_LEN-1:0] o_Hi,
    output logic [WORD_LEN-1:0] o_Lo
);

    localparam int CNT_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]    cnt;
    logic                is_div;
    logic                neg_q;        // negate quotient / product
    logic                neg_r;        // negate remainder (follows dividend sign)
    logic                div_zero;
    logic [WORD_LEN-1:0] dividend_raw; // original dividend, returned in Hi on divide-by-zero
    logic [WORD_LEN-1:0] opb_mag;      // multiplicand / divisor magnitude
    logic [WORD_LEN:0]   acc_hi;       // partial product upper half / running remainder
    logic [WORD_LEN-1:0] acc_lo;       // multiplier bits / dividend bits shifting into quotient

    logic                start_acc;
    logic                last_step;
    logic                a_neg, b_neg;
    logic [WORD_LEN-1:0] a_mag, b_mag;

    logic [WORD_LEN:0]     mul_sum;
    logic [WORD_LEN:0]     div_shift;
    logic [WORD_LEN+1:0]   div_trial;
    logic [WORD_LEN:0]     step_hi;
    logic [WORD_LEN-1:0]   step_lo;
    logic [2*WORD_LEN-1:0] prod_mag;
    logic [2*WORD_LEN-1:0] prod_fix;
    logic [WORD_LEN-1:0]   res_hi;
    logic [WORD_LEN-1:0]   res_lo;

    assign start_acc = (state == IDLE) && i_Start;
    assign last_step = (state == CALC) && (cnt == LAST_CNT);
    assign o_Busy    = (state != IDLE);
    assign o_Done    = (state == DONE);

    // Signed ops work on magnitudes; the most-negative value maps to 2^(WORD_LEN-1),
    // which still fits the unsigned WORD_LEN-bit magnitude.
    assign a_neg = i_Op[0] & i_Operand_A[WORD_LEN-1];
    assign b_neg = i_Op[0] & i_Operand_B[WORD_LEN-1];
    assign a_mag = a_neg ? -i_Operand_A : i_Operand_A;
    assign b_mag = b_neg ? -i_Operand_B : i_Operand_B;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_Start) state_nxt = CALC;
            CALC:    if (cnt == LAST_CNT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One iteration step plus the sign/zero fixup applied on the final step.
    always_comb begin
        mul_sum   = acc_hi + (acc_lo[0] ? {1'b0, opb_mag} : '0);
        div_shift = {acc_hi[WORD_LEN-1:0], acc_lo[WORD_LEN-1]};
        div_trial = {1'b0, div_shift} - {2'b00, opb_mag};
        step_hi   = '0;
        step_lo   = '0;
        res_hi    = '0;
        res_lo    = '0;

        if (is_div) begin
            // Restoring divide: keep the shifted remainder when the trial subtract goes negative.
            step_hi = div_trial[WORD_LEN+1] ? div_shift : div_trial[WORD_LEN:0];
            step_lo = {acc_lo[WORD_LEN-2:0], ~div_trial[WORD_LEN+1]};
        end else begin
            // Shift-add multiply: conditional add, then shift the whole accumulator right.
            step_hi = {1'b0, mul_sum[WORD_LEN:1]};
            step_lo = {mul_sum[0], acc_lo[WORD_LEN-1:1]};
        end

        prod_mag = {step_hi[WORD_LEN-1:0], step_lo};
        prod_fix = neg_q ? -prod_mag : prod_mag;

        if (is_div) begin
            if (div_zero) begin
                res_hi = dividend_raw;
                res_lo = '1;
            end else begin
                res_hi = neg_r ? -step_hi[WORD_LEN-1:0] : step_hi[WORD_LEN-1:0];
                res_lo = neg_q ? -step_lo : step_lo;
            end
        end else begin
            res_hi = prod_fix[2*WORD_LEN-1:WORD_LEN];
            res_lo = prod_fix[WORD_LEN-1:0];
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            cnt           <= '0;
            is_div        <= 1'b0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            div_zero      <= 1'b0;
            dividend_raw  <= '0;
            opb_mag       <= '0;
            acc_hi        <= '0;
            acc_lo        <= '0;
            o_Div_By_Zero <= 1'b0;
            o_Hi          <= '0;
            o_Lo          <= '0;
        end else if (start_acc) begin
            // Start wins over same-cycle MTHI/MTLO.
            cnt           <= '0;
            is_div        <= i_Op[1];
            neg_q         <= a_neg ^ b_neg;
            neg_r         <= a_neg;
            div_zero      <= (i_Operand_B == '0);
            dividend_raw  <= i_Operand_A;
            opb_mag       <= b_mag;
            acc_hi        <= '0;
            acc_lo        <= a_mag;
            o_Div_By_Zero <= 1'b0;
        end else if (state == IDLE) begin
            if (i_MTHI) o_Hi <= i_Operand_A;
            if (i_MTLO) o_Lo <= i_Operand_A;
        end else if (state == CALC) begin
            cnt    <= cnt + 1'b1;
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            if (last_step) begin
                o_Hi          <= res_hi;
                o_Lo          <= res_lo;
                o_Div_By_Zero <= is_div & div_zero;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases, then random ops vs a 64-bit arithmetic model.
// Latency: checks o_Done exactly WORD_LEN+1 cycles after the start cycle, and back-to-back issue.
// Backpressure: pulses start/MT requests mid-operation and expects them to be ignored.

module tb_mult_div_unit;

    localparam int WL = 32;

    logic          i_CLK;
    logic          i_RST;
    logic          i_Start;
    logic [1:0]    i_Op;
    logic [WL-1:0] i_Operand_A;
    logic [WL-1:0] i_Operand_B;
    logic          i_MTHI;
    logic          i_MTLO;
    logic          o_Busy;
    logic          o_Done;
    logic          o_Div_By_Zero;
    logic [WL-1:0] o_Hi;
    logic [WL-1:0] o_Lo;

    int compared   = 0;
    int mismatched = 0;

    logic [WL-1:0] exp_hi;
    logic [WL-1:0] exp_lo;
    logic          exp_dz;

    mult_div_unit #(.WORD_LEN(WL)) dut (
        .i_CLK         (i_CLK),
        .i_RST         (i_RST),
        .i_Start       (i_Start),
        .i_Op          (i_Op),
        .i_Operand_A   (i_Operand_A),
        .i_Operand_B   (i_Operand_B),
        .i_MTHI        (i_MTHI),
        .i_MTLO        (i_MTLO),
        .o_Busy        (o_Busy),
        .o_Done        (o_Done),
        .o_Div_By_Zero (o_Div_By_Zero),
        .o_Hi          (o_Hi),
        .o_Lo          (o_Lo)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural result computed directly with wide integer arithmetic.
    function automatic void model(input logic [1:0] op, input logic [WL-1:0] a, input logic [WL-1:0] b,
                                  output logic [WL-1:0] hi, output logic [WL-1:0] lo, output logic dz);
        logic [63:0] up;
        longint      sa, sb, sp, sq, sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin
                up = {32'h0, a} * {32'h0, b};
                hi = up[63:32];
                lo = up[31:0];
            end
            2'b01: begin
                sp = sa * sb;
                hi = sp[63:32];
                lo = sp[31:0];
            end
            default: begin
                if (b == '0) begin
                    dz = 1'b1;
                    hi = a;
                    lo = '1;
                end else if (op == 2'b10) begin
                    lo = a / b;
                    hi = a % b;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    lo = sq[31:0];
                    hi = sr[31:0];
                end
            end
        endcase
    endfunction

    // Called at posedge+1 with the DUT idle; returns at posedge+1 of the idle cycle after DONE.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [WL-1:0] a,
                          input logic [WL-1:0] b, input bit mt_with_start, input int disturb_at);
        logic [WL-1:0] mh, ml;
        logic          mdz;
        logic          bad_mid;
        model(op, a, b, mh, ml, mdz);
        i_Start     = 1'b1;
        i_Op        = op;
        i_Operand_A = a;
        i_Operand_B = b;
        i_MTHI      = mt_with_start;
        i_MTLO      = mt_with_start;
        @(posedge i_CLK); #1;
        // Scramble inputs after acceptance: the latched values must be used.
        i_Start     = 1'b0;
        i_MTHI      = 1'b0;
        i_MTLO      = 1'b0;
        i_Op        = 2'($urandom);
        i_Operand_A = $urandom;
        i_Operand_B = $urandom;
        exp_dz      = 1'b0;
        bad_mid     = 1'b0;
        for (int k = 1; k <= WL; k++) begin
            if (o_Done !== 1'b0 || o_Busy !== 1'b1 || o_Hi !== exp_hi || o_Lo !== exp_lo ||
                o_Div_By_Zero !== exp_dz)
                bad_mid = 1'b1;
            if (k == disturb_at) begin
                i_Start     = 1'b1;
                i_MTHI      = 1'b1;
                i_MTLO      = 1'b1;
                i_Op        = 2'($urandom);
                i_Operand_A = $urandom;
            end else begin
                i_Start = 1'b0;
                i_MTHI  = 1'b0;
                i_MTLO  = 1'b0;
            end
            @(posedge i_CLK); #1;
        end
        i_Start = 1'b0;
        i_MTHI  = 1'b0;
        i_MTLO  = 1'b0;
        check({tag, ":calc"}, 64'(bad_mid), 64'd0);
        exp_hi = mh;
        exp_lo = ml;
        exp_dz = mdz;
        check({tag, ":done"}, 64'(o_Done), 64'd1);
        check({tag, ":hi"},   64'(o_Hi), 64'(exp_hi));
        check({tag, ":lo"},   64'(o_Lo), 64'(exp_lo));
        check({tag, ":dz"},   64'(o_Div_By_Zero), 64'(exp_dz));
        @(posedge i_CLK); #1;
        check({tag, ":idle"}, 64'({o_Busy, o_Done}), 64'd0);
    endtask

    task automatic mt_write(input string tag, input bit hi_en, input bit lo_en, input logic [WL-1:0] val);
        i_MTHI      = hi_en;
        i_MTLO      = lo_en;
        i_Operand_A = val;
        i_Start     = 1'b0;
        i_Op        = 2'($urandom);
        @(posedge i_CLK); #1;
        i_MTHI = 1'b0;
        i_MTLO = 1'b0;
        if (hi_en) exp_hi = val;
        if (lo_en) exp_lo = val;
        check({tag, ":hi"}, 64'(o_Hi), 64'(exp_hi));
        check({tag, ":lo"}, 64'(o_Lo), 64'(exp_lo));
    endtask

    initial begin
        logic          bad;
        logic [1:0]    rop;
        logic [WL-1:0] ra, rb;
        int            sel;

        i_RST       = 1'b0;
        i_Start     = 1'b0;
        i_Op        = 2'b00;
        i_Operand_A = '0;
        i_Operand_B = '0;
        i_MTHI      = 1'b0;
        i_MTLO      = 1'b0;
        exp_hi      = '0;
        exp_lo      = '0;
        exp_dz      = 1'b0;

        // Asynchronous reset, observed before any clock edge.
        #2 i_RST = 1'b1;
        #1;
        check("reset", 64'({o_Busy, o_Done, o_Div_By_Zero}), 64'd0);
        check("reset_hi", 64'(o_Hi), 64'd0);
        check("reset_lo", 64'(o_Lo), 64'd0);
        @(posedge i_CLK);
        @(posedge i_CLK); #1;
        i_RST = 1'b0;

        // Start on the first edge after reset release.
        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        check("multu_max_hi_const", 64'(o_Hi), 64'hFFFF_FFFE);
        check("multu_max_lo_const", 64'(o_Lo), 64'h0000_0001);

        run_op("mult_m7x3", 2'b01, 32'hFFFF_FFF9, 32'd3, 1'b0, 0);
        check("mult_m7x3_const", {32'(o_Hi), 32'(o_Lo)}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        check("div_m7d2_const", {32'(o_Hi), 32'(o_Lo)}, 64'hFFFF_FFFF_FFFF_FFFD);

        run_op("divu_100d0", 2'b10, 32'd100, 32'd0, 1'b0, 0);
        check("divu_100d0_const", {31'd0, o_Div_By_Zero, 32'(o_Lo)}, 64'h1_FFFF_FFFF);
        run_op("divu_100d7", 2'b10, 32'd100, 32'd7, 1'b0, 0);
        check("divu_100d7_const", {o_Div_By_Zero, 31'(o_Hi), 32'(o_Lo)}, 64'h0000_0002_0000_000E);

        run_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        check("div_min_m1_const", {31'd0, o_Div_By_Zero, 32'(o_Lo)}, 64'h0_8000_0000);

        run_op("div_neg_zero", 2'b11, 32'hFFFF_FF00, 32'd0, 1'b0, 0);

        // Requests while busy are ignored; start beats MT in the same idle cycle.
        run_op("disturb10", 2'b01, 32'h1234_5678, 32'hFEDC_BA98, 1'b0, 10);
        run_op("start_vs_mt", 2'b00, 32'hDEAD_BEEF, 32'h0000_0010, 1'b1, 0);

        mt_write("mthi", 1'b1, 1'b0, 32'h0000_1234);
        mt_write("mtlo", 1'b0, 1'b1, 32'hCAFE_F00D);
        mt_write("mt_both", 1'b1, 1'b1, 32'h5A5A_A5A5);

        // Reset in CALC cycle 16: everything clears at once, no DONE pulse follows.
        run_op("pre_rst", 2'b00, 32'h0001_0001, 32'h0003_0003, 1'b0, 0);
        i_Start     = 1'b1;
        i_Op        = 2'b00;
        i_Operand_A = 32'h7777_7777;
        i_Operand_B = 32'h3333_3333;
        @(posedge i_CLK); #1;
        i_Start = 1'b0;
        for (int k = 1; k < 16; k++) begin
            @(posedge i_CLK); #1;
        end
        #2 i_RST = 1'b1;
        #1;
        check("midrst_busy", 64'({o_Busy, o_Done, o_Div_By_Zero}), 64'd0);
        check("midrst_hilo", {32'(o_Hi), 32'(o_Lo)}, 64'd0);
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_CLK); #1;
            if (o_Done !== 1'b0 || o_Busy !== 1'b0) bad = 1'b1;
        end
        check("midrst_held", 64'(bad), 64'd0);
        i_RST  = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        exp_dz = 1'b0;
        run_op("post_rst", 2'b11, 32'h8000_0001, 32'd3, 1'b0, 0);

        // Random operations, back-to-back, with occasional MT writes and disturbances.
        for (int n = 0; n < 24; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = '0;
            else if (sel == 1) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end else if (sel == 2) rb = 32'($urandom_range(1, 15));
            else if (sel == 3) ra = 32'($urandom_range(0, 20));
            if ($urandom_range(0, 3) == 0)
                mt_write($sformatf("rnd%0d_mt", n), 1'($urandom), 1'($urandom), $urandom);
            run_op($sformatf("rnd%0d_op%0d", n, rop), rop, ra, rb, 1'($urandom),
                   ($urandom_range(0, 2) == 0) ? $urandom_range(1, WL) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WORD_LEN, default 32, meaning operand/result width.
REQ-002 SHALL have port i_CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_Start  input  1  request new operation; sampled only in IDLE.
REQ-005 SHALL have port i_Op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port i_Operand_A  input  WORD_LEN  rs read data (multiplicand/dividend).
REQ-007 SHALL have port i_Operand_B  input  WORD_LEN  rt read data (multiplier/divisor).
REQ-008 SHALL have port i_MTHI  input  1  write i_Operand_A into Hi.
REQ-009 SHALL have port i_MTLO  input  1  write i_Operand_A into Lo.
REQ-010 SHALL have port o_Busy  output  1  high while state is not IDLE.
REQ-011 SHALL have port o_Done  output  1  one-cycle pulse, result valid in Hi/Lo.
REQ-012 SHALL have port o_Div_By_Zero  output  1  sticky per operation: last divide had divisor 0.
REQ-013 SHALL have port o_Hi  output  WORD_LEN  Hi register (product upper / remainder).
REQ-014 SHALL have port o_Lo  output  WORD_LEN  Lo register (product lower / quotient).

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE; IDLE->CALC on i_Start; CALC->DONE after exactly WORD_LEN CALC cycles; DONE->IDLE unconditionally.
REQ-016 SHALL latch i_Op, i_Operand_A, i_Operand_B on the accepting edge; later operand changes have no effect.
REQ-017 SHALL compute with radix-2 shift-add (multiply) and restoring shift-subtract (divide), one bit per CALC cycle, on operand magnitudes.
REQ-018 SHALL update o_Hi/o_Lo only on the CALC->DONE edge; o_Done high exactly during the DONE cycle, i.e. WORD_LEN+1 cycles after the accepting edge.
REQ-019 SHALL for MULT/MULTU produce {Hi,Lo} = full 2*WORD_LEN-bit signed/unsigned product.
REQ-020 SHALL for DIV/DIVU produce Lo = quotient, Hi = remainder; signed quotient truncates toward zero, remainder takes sign of dividend.
REQ-021 SHALL for DIV of most-negative value by -1 produce Lo = most-negative value, Hi = 0, no flag.
REQ-022 SHALL for divisor 0 run full latency, produce Lo = all ones, Hi = dividend, set o_Div_By_Zero; flag cleared by next accepted i_Start.
REQ-023 SHALL ignore i_Start, i_MTHI, i_MTLO while o_Busy is high; Hi/Lo stay stable until DONE edge.
REQ-024 SHALL in IDLE write Hi/Lo on the edge i_MTHI/i_MTLO is high; both high writes both.
REQ-025 SHALL give i_Start priority over i_MTHI/i_MTLO in the same IDLE cycle (MT writes dropped).
REQ-026 SHALL accept a new i_Start in the cycle after DONE (back-to-back throughput WORD_LEN+2 cycles).
REQ-027 SHALL treat i_Op as a don't-care when i_Start is low.

Reset
REQ-028 SHALL on i_RST high, immediately and independent of i_CLK: state IDLE, o_Busy 0, o_Done 0, o_Div_By_Zero 0, o_Hi 0, o_Lo 0, counter 0.
REQ-029 SHALL abort any in-flight operation on reset with no o_Done pulse and no partial result visible.
REQ-030 SHALL accept i_Start on the first rising edge after i_RST deasserts.

Verification
REQ-031 SHALL verify MULTU 0xFFFFFFFF*0xFFFFFFFF -> o_Done at cycle 33 after start, Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-032 SHALL verify MULT -7*3 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; DIV -7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
REQ-033 SHALL verify DIVU 100/0 -> Lo=0xFFFFFFFF, Hi=100, o_Div_By_Zero=1; next DIVU 100/7 -> Lo=14, Hi=2, flag 0.
REQ-034 SHALL verify DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0, flag 0.
REQ-035 SHALL verify i_Start and i_MTLO pulsed at cycle 10 of a running op -> ignored, result unchanged; i_MTHI=0x1234 in IDLE -> o_Hi=0x1234 next cycle.
REQ-036 SHALL verify i_RST asserted at CALC cycle 16 -> o_Busy/o_Hi/o_Lo 0 immediately, no o_Done, fresh op after release completes correctly.
